serial_paralelo_rx: RTL and testbench
=====================================

Name: serial_paralelo_rx

Overview:
- Receive end of the 4-lane byte-striped serial link; mirror of the parallel-to-serial transmit chain.
- Samples the 1-bit serial line at clk_32f and finds byte alignment by hunting for the COMMA symbol.
- Declares the link active after LOCK_COUNT aligned commas, then emits one byte per 8 bits with a valid flag.
- Feeds the downstream 1-to-2 / 2-to-4 demux stages, which rebuild data_0..data_3.

Parameters:
- COMMA, 8'hBC, idle/alignment symbol the transmitter sends when valid_000 is low.
- LOCK_COUNT, 4, consecutive aligned COMMA bytes required before ACTIVE; legal range 1..15.

Ports:
- clk_32f  input  1  bit clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  1  serial line; MSB of each byte first.
- data_000  output  8  last received non-comma byte; holds between strobes.
- valid_000  output  1  high when the byte just strobed is data (not COMMA); updates only on byte_strobe.
- byte_strobe  output  1  one-cycle pulse per completed aligned byte in ACTIVE.
- active  output  1  high while in ACTIVE.
- IDLE_OUT  output  1  high when not ACTIVE, or when the last strobed byte was COMMA.

Behaviour:
- Reset (reset=0, async): state=SEARCH; shift_reg=0, bit_cnt=0, comma_cnt=0.
- Reset output values: data_000=8'h00, valid_000=0, byte_strobe=0, active=0, IDLE_OUT=1.
- Shift register, every posedge: shift_reg <= {shift_reg[6:0], data_in}.
- cand = {shift_reg[6:0], data_in} is the combinational candidate byte.
- SEARCH: compare cand to COMMA every cycle (bit-sliding hunt).
  - On match: bit_cnt<=0, comma_cnt<=1.
  - If LOCK_COUNT==1, go straight to ACTIVE; otherwise go to LOCKING.
- LOCKING: bit_cnt increments mod 8; cand is evaluated only when bit_cnt==7.
  - cand==COMMA: comma_cnt++. When the new count equals LOCK_COUNT, go to ACTIVE.
  - cand!=COMMA: comma_cnt<=0, go back to SEARCH. The bit hunt resumes on the next cycle.
- ACTIVE: bit_cnt increments mod 8. When bit_cnt==7 (registered, visible after that edge):
  - byte_strobe<=1.
  - If cand!=COMMA: data_000<=cand, valid_000<=1, IDLE_OUT<=0.
  - If cand==COMMA: data_000 holds, valid_000<=0, IDLE_OUT<=1.
  - On all other cycles byte_strobe<=0.
- Loss of sync: none. ACTIVE holds until reset, and non-comma data is never treated as misalignment.
- Latency: the 8th bit of a byte is sampled at edge k; data_000, valid_000 and byte_strobe are valid after edge k. No further pipeline stage.
- active: registered, rises the edge the lock-completing comma is sampled, and stays high.
- Reset asserted mid-byte or mid-lock: counters and partial byte are discarded; re-hunt from SEARCH after deassertion.
- Bit-slip: while SEARCH/LOCKING, a false COMMA match inside data causes a retry. No outputs change before ACTIVE.
- Widths:
  - bit_cnt is 3 bits and wraps 7->0.
  - comma_cnt is 4 bits and saturates at LOCK_COUNT.

Decomposition:
- Shared package/include (shared with the transmitter): COMMA value, default LOCK_COUNT, state encodings SEARCH=2'd0, LOCKING=2'd1, ACTIVE=2'd2.
- One natural sub-module: comma_detector, holding the shift register plus the cand==COMMA comparison.
- The FSM and counters stay in serial_paralelo_rx.

Test Plan:
- Reset held low while data_in toggles: all outputs at reset values, IDLE_OUT=1; release shows no strobe until lock.
- Send 3 junk bits, then 4x 8'hBC: active rises on the 4th comma's last bit; no byte_strobe before then; data_000=8'h00.
- After lock, send 8'hA5, 8'hBC, 8'h3C: three strobes 8 cycles apart.
  - A5 -> data_000=A5, valid_000=1, IDLE_OUT=0.
  - BC -> valid_000=0, IDLE_OUT=1, data_000 stays A5.
  - 3C -> data_000=3C, valid_000=1.
- Send 2x 8'hBC, then 8'h00, then 4x 8'hBC: comma_cnt resets on 00, and active rises only after the final 4 commas.
- Assert reset for 1 cycle mid-byte while ACTIVE: outputs return to reset values immediately (async). Relock needs 4 fresh commas.
- Loopback with the 4-lane transmit chain (lanes 0..3 = 8'h11/22/33/44, all valid): after lock, strobes give 11,22,33,44 repeating with valid_000=1.

Source files
------------

// File: rtl/serial_paralelo_rx_pkg.sv
// rtl/serial_paralelo_rx_pkg.sv - link symbols and receive FSM state encoding shared with the transmit chain
package serial_paralelo_rx_pkg;

   // Idle/alignment symbol sent by the transmitter whenever it has no valid data
   localparam logic [7:0] COMMA = 8'hBC;

   // Default number of consecutive aligned commas before the link is declared active
   localparam int unsigned LOCK_COUNT_DEFAULT = 4;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      LOCKING = 2'd1,
      ACTIVE  = 2'd2
   } link_state_e;

endpackage

// File: rtl/serial_paralelo_rx_comma_detector.sv
// rtl/serial_paralelo_rx_comma_detector.sv - serial shift register and comma match on the candidate byte
module serial_paralelo_rx_comma_detector
   import serial_paralelo_rx_pkg::*;
(
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] cand_o,
   output logic       is_comma_o
);

   // Only the seven most recent bits are stored: the candidate byte is completed
   // combinationally by the bit currently on the line, so the oldest bit is never read.
   logic [6:0] shift_q;
   logic [6:0] shift_d;

   assign cand_o     = {shift_q, data_in};
   assign is_comma_o = (cand_o == COMMA);
   assign shift_d    = cand_o[6:0];

   // Shift the serial line in MSB first on every bit clock
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         shift_q <= 7'd0;
      end else begin
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/serial_paralelo_rx.sv
// rtl/serial_paralelo_rx.sv - serial receiver: comma hunt, lock counting and aligned byte strobes
module serial_paralelo_rx
   import serial_paralelo_rx_pkg::*;
#(
   parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       data_in,
   output logic [7:0] data_000,
   output logic       valid_000,
   output logic       byte_strobe,
   output logic       active,
   output logic       IDLE_OUT
);

   localparam logic [3:0] LOCK_CNT4 = 4'(LOCK_COUNT);

   logic [7:0]  cand;
   logic        is_comma;

   link_state_e state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [3:0]  comma_cnt_q, comma_cnt_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        strobe_q, strobe_d;
   logic        active_q, active_d;
   logic        idle_q, idle_d;

   serial_paralelo_rx_comma_detector u_comma_detector (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .data_in    (data_in),
      .cand_o     (cand),
      .is_comma_o (is_comma)
   );

   // Next-state and output decisions; bytes are only judged on the 8th bit once aligned
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      comma_cnt_d = comma_cnt_q;
      data_d      = data_q;
      valid_d     = valid_q;
      strobe_d    = 1'b0;
      active_d    = active_q;
      idle_d      = idle_q;
      case (state_q)
         SEARCH: begin
            // Bit-sliding hunt: every cycle is a possible byte boundary
            bit_cnt_d = 3'd0;
            if (is_comma) begin
               comma_cnt_d = 4'd1;
               if (LOCK_CNT4 == 4'd1) begin
                  state_d  = ACTIVE;
                  active_d = 1'b1;
               end else begin
                  state_d = LOCKING;
               end
            end
         end
         LOCKING: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               if (is_comma) begin
                  comma_cnt_d = comma_cnt_q + 4'd1;
                  if ((comma_cnt_q + 4'd1) == LOCK_CNT4) begin
                     state_d  = ACTIVE;
                     active_d = 1'b1;
                  end
               end else begin
                  // A non-comma here means the earlier match was a false hit inside data
                  comma_cnt_d = 4'd0;
                  state_d     = SEARCH;
               end
            end
         end
         ACTIVE: begin
            // Once active the link never drops; data bytes are not misalignment
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               strobe_d = 1'b1;
               if (is_comma) begin
                  valid_d = 1'b0;
                  idle_d  = 1'b1;
               end else begin
                  data_d  = cand;
                  valid_d = 1'b1;
                  idle_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = SEARCH;
         end
      endcase
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         state_q     <= SEARCH;
         bit_cnt_q   <= 3'd0;
         comma_cnt_q <= 4'd0;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         strobe_q    <= 1'b0;
         active_q    <= 1'b0;
         idle_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         comma_cnt_q <= comma_cnt_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         strobe_q    <= strobe_d;
         active_q    <= active_d;
         idle_q      <= idle_d;
      end
   end

   assign data_000    = data_q;
   assign valid_000   = valid_q;
   assign byte_strobe = strobe_q;
   assign active      = active_q;
   assign IDLE_OUT    = idle_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb/tb_serial_paralelo_rx.sv - scoreboard bench for serial_paralelo_rx against a bit-stream reference model
module tb_serial_paralelo_rx;

   localparam logic [7:0] K_COMMA = 8'hBC;
   localparam int         K_LOCK  = 4;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_000;
   logic       valid_000;
   logic       byte_strobe;
   logic       active;
   logic       IDLE_OUT;

   always #5 clk_32f = ~clk_32f;

   serial_paralelo_rx #(.LOCK_COUNT(K_LOCK)) dut (
      .clk_32f     (clk_32f),
      .reset       (reset),
      .data_in     (data_in),
      .data_000    (data_000),
      .valid_000   (valid_000),
      .byte_strobe (byte_strobe),
      .active      (active),
      .IDLE_OUT    (IDLE_OUT)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   typedef struct packed {
      logic [7:0] data;
      logic       valid;
      logic       idle;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: a window of the last 8 bits on the line, a hunting flag,
   // a count of bits gathered for the current byte and a count of good commas.
   int         m_mode;
   logic [7:0] m_win;
   int         m_nbits;
   int         m_commas;
   logic [7:0] m_last;
   int         cyc = 0;
   int         last_strobe_cyc = -1;

   always @(posedge clk_32f) cyc++;

   task automatic model_reset();
      m_mode   = 0;
      m_win    = 8'h00;
      m_nbits  = 0;
      m_commas = 0;
      m_last   = 8'h00;
      exp_q.delete();
      last_strobe_cyc = -1;
   endtask

   task automatic model_step(input logic b);
      exp_t e;
      m_win = {m_win[6:0], b};
      if (m_mode == 0) begin
         if (m_win == K_COMMA) begin
            m_nbits  = 0;
            m_commas = 1;
            m_mode   = (K_LOCK == 1) ? 2 : 1;
         end
      end else begin
         m_nbits++;
         if (m_nbits == 8) begin
            m_nbits = 0;
            if (m_mode == 1) begin
               if (m_win == K_COMMA) begin
                  m_commas++;
                  if (m_commas == K_LOCK) m_mode = 2;
               end else begin
                  m_commas = 0;
                  m_mode   = 0;
               end
            end else begin
               if (m_win != K_COMMA) m_last = m_win;
               e.data  = m_last;
               e.valid = (m_win != K_COMMA);
               e.idle  = (m_win == K_COMMA);
               exp_q.push_back(e);
            end
         end
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk_32f);
      check("active_track", {31'd0, active}, {31'd0, (m_mode == 2)});
      data_in = b;
      model_step(b);
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic release_reset();
      @(negedge clk_32f);
      model_reset();
      reset   = 1'b1;
      data_in = 1'b0;
      model_step(1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},   {24'd0, data_000},    32'h00);
      check({tag, "_valid"},  {31'd0, valid_000},   32'd0);
      check({tag, "_strobe"}, {31'd0, byte_strobe}, 32'd0);
      check({tag, "_active"}, {31'd0, active},      32'd0);
      check({tag, "_idle"},   {31'd0, IDLE_OUT},    32'd1);
   endtask

   task automatic after_edge();
      @(posedge clk_32f);
      #1;
   endtask

   // Scoreboard monitor: every strobe pops one expected byte and must be 8 cycles after the previous one
   always @(negedge clk_32f) begin
      exp_t e;
      if (reset && byte_strobe) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_strobe: got strobe data=%0h expected no strobe at %0t", data_000, $time);
         end else begin
            e = exp_q.pop_front();
            check("sb_data",  {24'd0, data_000},  {24'd0, e.data});
            check("sb_valid", {31'd0, valid_000}, {31'd0, e.valid});
            check("sb_idle",  {31'd0, IDLE_OUT},  {31'd0, e.idle});
         end
         if (last_strobe_cyc >= 0) check("strobe_gap", cyc - last_strobe_cyc, 32'd8);
         last_strobe_cyc = cyc;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] lanes [4];
      logic [7:0] rb;
      int         njunk;
      lanes[0] = 8'h11; lanes[1] = 8'h22; lanes[2] = 8'h33; lanes[3] = 8'h44;
      model_reset();

      // Reset held while the line toggles
      for (int i = 0; i < 16; i++) begin
         @(negedge clk_32f);
         data_in = ~data_in;
         if (i % 4 == 3) check_reset_outputs("rst_hold");
      end

      // Junk bits then lock on four commas
      release_reset();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      send_byte(K_COMMA); send_byte(K_COMMA); send_byte(K_COMMA);
      for (int i = 7; i >= 1; i--) send_bit(K_COMMA[i]);
      after_edge();
      check("lock_pre_active", {31'd0, active}, 32'd0);
      send_bit(K_COMMA[0]);
      after_edge();
      check("lock_active", {31'd0, active},    32'd1);
      check("lock_data",   {24'd0, data_000},  32'h00);
      check("lock_strobe", {31'd0, byte_strobe}, 32'd0);
      check("lock_idle",   {31'd0, IDLE_OUT},  32'd1);

      // Data, comma, data after lock
      send_byte(8'hA5);
      after_edge();
      check("a5_strobe", {31'd0, byte_strobe}, 32'd1);
      check("a5_data",   {24'd0, data_000},    32'hA5);
      check("a5_valid",  {31'd0, valid_000},   32'd1);
      check("a5_idle",   {31'd0, IDLE_OUT},    32'd0);
      send_byte(K_COMMA);
      after_edge();
      check("bc_data",   {24'd0, data_000},    32'hA5);
      check("bc_valid",  {31'd0, valid_000},   32'd0);
      check("bc_idle",   {31'd0, IDLE_OUT},    32'd1);
      send_byte(8'h3C);
      after_edge();
      check("3c_data",   {24'd0, data_000},    32'h3C);
      check("3c_valid",  {31'd0, valid_000},   32'd1);

      // Asynchronous reset mid-byte while active
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      release_reset();

      // Two commas, a zero byte, then four fresh commas
      send_byte(K_COMMA); send_byte(K_COMMA); send_byte(8'h00);
      send_byte(K_COMMA); send_byte(K_COMMA); send_byte(K_COMMA);
      after_edge();
      check("relock_pre_active", {31'd0, active}, 32'd0);
      send_byte(K_COMMA);
      after_edge();
      check("relock_active", {31'd0, active}, 32'd1);

      // Loopback of the four-lane stripe
      for (int r = 0; r < 3; r++)
         for (int l = 0; l < 4; l++) send_byte(lanes[l]);

      // Randomized rounds: junk bits, lock, mixed data/comma traffic
      for (int r = 0; r < 4; r++) begin
         @(negedge clk_32f);
         reset = 1'b0;
         release_reset();
         njunk = $urandom_range(0, 12);
         for (int i = 0; i < njunk; i++) send_bit(1'($urandom_range(0, 1)));
         for (int i = 0; i < K_LOCK; i++) send_byte(K_COMMA);
         for (int i = 0; i < 24; i++) begin
            rb = ($urandom_range(0, 3) == 0) ? K_COMMA : 8'($urandom);
            send_byte(rb);
         end
      end

      send_byte(K_COMMA);
      @(negedge clk_32f);
      @(negedge clk_32f);
      check("sb_drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
